// File: rtl/crash_monitor.sv
// Plane/obstacle collision monitor: snapshots obstacle positions on each frame tick,
// scans channels one per cycle, and manages lives, grace period and game over.
module crash_monitor #(
  parameter int NUM_OBS      = 3,
  parameter int COORD_W      = 10,
  parameter int PLANE_X      = 120,
  parameter int PLANE_SIZE   = 16,
  parameter int LIVES        = 3,
  parameter int GRACE_FRAMES = 60
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       frame_tick,
  input  logic [COORD_W-1:0]         plane_y,
  input  logic [NUM_OBS*COORD_W-1:0] obs_x,
  input  logic [NUM_OBS*COORD_W-1:0] obs_y,
  input  logic [NUM_OBS-1:0]         obs_kind,
  input  logic [NUM_OBS-1:0]         obs_en,
  output logic                       game_over,
  output logic [3:0]                 lives,
  output logic                       hit_pulse,
  output logic [3:0]                 hit_index,
  output logic                       busy,
  output logic                       invuln,
  output logic [2:0]                 dbg_state
);

  // Timing contract: frame_tick is a one-cycle pulse, accepted only in IDLE (it
  // starts a scan) or GRACE (it counts down); ticks in any other state are dropped.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_HIT   = 3'd2,
    S_GRACE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [COORD_W:0] PLANE_X_END = (COORD_W+1)'(PLANE_X + PLANE_SIZE);
  localparam logic [COORD_W:0] SIZE_EXT    = (COORD_W+1)'(PLANE_SIZE);

  state_t                     state, state_nx;
  logic [COORD_W-1:0]         snap_py;
  logic [NUM_OBS*COORD_W-1:0] snap_ox, snap_oy;
  logic [NUM_OBS-1:0]         snap_kind, snap_en;
  logic [3:0]                 idx;
  logic [7:0]                 grace_cnt;

  logic [COORD_W-1:0] cur_ox, cur_oy;
  logic               cur_kind, cur_en;
  logic [COORD_W:0]   py_end;
  logic               chan_hit, last_chan;

  always_comb begin
    cur_ox   = '0;
    cur_oy   = '0;
    cur_kind = 1'b0;
    cur_en   = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (idx == 4'(i)) begin
        cur_ox   = snap_ox[i*COORD_W +: COORD_W];
        cur_oy   = snap_oy[i*COORD_W +: COORD_W];
        cur_kind = snap_kind[i];
        cur_en   = snap_en[i];
      end
    end
  end

  // One extra bit keeps plane bottom near the screen edge from wrapping.
  assign py_end    = {1'b0, snap_py} + SIZE_EXT;
  assign chan_hit  = cur_en && (PLANE_X_END >= {1'b0, cur_ox}) &&
                     (cur_kind ? (snap_py == cur_oy) : (py_end >= {1'b0, cur_oy}));
  assign last_chan = (idx == 4'(NUM_OBS - 1));

  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    hit_pulse = 1'b0;
    invuln    = 1'b0;
    case (state)
      S_IDLE:  if (frame_tick) state_nx = S_SCAN;
      S_SCAN: begin
        busy = 1'b1;
        if (chan_hit)       state_nx = S_HIT;
        else if (last_chan) state_nx = S_IDLE;
      end
      S_HIT: begin
        hit_pulse = 1'b1;
        state_nx  = (lives == 4'd0) ? S_OVER : S_GRACE;
      end
      S_GRACE: begin
        invuln = 1'b1;
        if (frame_tick && grace_cnt <= 8'd1) state_nx = S_IDLE;
      end
      S_OVER:  state_nx = S_OVER;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= S_IDLE;
      lives     <= 4'(LIVES);
      hit_index <= '0;
      idx       <= '0;
      grace_cnt <= '0;
      snap_py   <= '0;
      snap_ox   <= '0;
      snap_oy   <= '0;
      snap_kind <= '0;
      snap_en   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (frame_tick) begin
          snap_py   <= plane_y;
          snap_ox   <= obs_x;
          snap_oy   <= obs_y;
          snap_kind <= obs_kind;
          snap_en   <= obs_en;
          idx       <= '0;
        end
        // Lives drop on entry to HIT so the HIT cycle already shows the new count.
        S_SCAN: if (chan_hit) begin
          hit_index <= idx;
          lives     <= (lives == 4'd0) ? 4'd0 : lives - 4'd1;
        end else begin
          idx <= idx + 4'd1;
        end
        S_HIT: if (lives != 4'd0) grace_cnt <= 8'(GRACE_FRAMES);
        S_GRACE: if (frame_tick && grace_cnt != 8'd0) grace_cnt <= grace_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  assign game_over = (state == S_OVER) || !resetn;
  assign dbg_state = state;

endmodule
